// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state encoding for the MAC operand packer
package mac_pkg;

  localparam logic MODE_4B = 1'b0;
  localparam logic MODE_2B = 1'b1;

  localparam int BW  = 4;
  localparam int ROW = 8;

  // Width of the activation slice kept per lane in 2-bit SIMD mode.
  localparam int ACT_LO_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } pack_state_t;

endpackage

// File: rtl/packer_out_reg.sv
// rtl/packer_out_reg.sv - single valid/ready output register stage (load, hold, drain)
module packer_out_reg #(
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [dw-1:0] load_data,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic [dw-1:0] out_data
);

  // Keeps the stage closed during reset so in_ready rises one cycle after release.
  logic rst_done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rst_done  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign in_ready = rst_done & (!out_valid | out_ready);

endmodule

// File: rtl/mac_operand_packer.sv
// rtl/mac_operand_packer.sv - packs activation/weight beats into {a, b0, b1} MAC operands
// Optional statistics counters are enabled with the PACKER_STATS_EN macro.
module mac_operand_packer
  import mac_pkg::*;
#(
  parameter int bw  = BW,
  parameter int row = ROW
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [row*bw-1:0]   in_act,
  input  logic [row*bw-1:0]   in_w,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [row*bw-1:0]   out_a,
  output logic [row*bw-1:0]   out_b0,
  output logic [row*bw-1:0]   out_b1,
  output logic                out_last
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]         beat_cnt,
  output logic [15:0]         pad_cnt
`else
`endif
);

  localparam int dw = row * bw;

  pack_state_t                 state;
  logic                        mode_r;
  logic                        in_vec;
  logic [row*ACT_LO_W-1:0]     hold_a;
  logic [dw-1:0]               hold_w;

  logic                        accept;
  logic                        eff_mode;
  logic                        half_store;
  logic                        flush;
  logic                        load;
  logic [dw-1:0]               nxt_a;
  logic [dw-1:0]               nxt_b0;
  logic [dw-1:0]               nxt_b1;
  logic [3*dw:0]               load_data;
  logic [3*dw:0]               out_data;

  assign accept     = in_valid & in_ready;
  // Mode is only honoured on the first beat of a vector.
  assign eff_mode   = in_vec ? mode_r : mode;
  assign half_store = accept & (state == IDLE) & (eff_mode == MODE_2B) & !in_last;
  assign flush      = accept & (state == IDLE) & (eff_mode == MODE_2B) & in_last;
  assign load       = accept & !half_store;

  always_comb begin
    nxt_a = '0;
    for (int i = 0; i < row; i++) begin
      if (state == HALF) begin
        nxt_a[bw*i +: ACT_LO_W]            = hold_a[ACT_LO_W*i +: ACT_LO_W];
        nxt_a[bw*i + ACT_LO_W +: ACT_LO_W] = in_act[bw*i +: ACT_LO_W];
      end else if (eff_mode == MODE_2B) begin
        nxt_a[bw*i +: ACT_LO_W] = in_act[bw*i +: ACT_LO_W];
      end else begin
        nxt_a[bw*i +: bw] = in_act[bw*i +: bw];
      end
    end
  end

  assign nxt_b0    = (state == HALF) ? hold_w : in_w;
  assign nxt_b1    = (state == HALF) ? in_w : '0;
  assign load_data = {in_last, nxt_a, nxt_b0, nxt_b1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      mode_r <= 1'b0;
      in_vec <= 1'b0;
      hold_a <= '0;
      hold_w <= '0;
    end else if (accept) begin
      if (!in_vec) begin
        mode_r <= mode;
        in_vec <= !in_last;
      end else if (in_last) begin
        in_vec <= 1'b0;
      end
      if (half_store) begin
        for (int i = 0; i < row; i++) begin
          hold_a[ACT_LO_W*i +: ACT_LO_W] <= in_act[bw*i +: ACT_LO_W];
        end
        hold_w <= in_w;
        state  <= HALF;
      end else begin
        state <= IDLE;
      end
    end
  end

  packer_out_reg #(
    .dw (3*dw + 1)
  ) u_out_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign out_last = out_data[3*dw];
  assign out_a    = out_data[3*dw-1 -: dw];
  assign out_b0   = out_data[2*dw-1 -: dw];
  assign out_b1   = out_data[dw-1:0];

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      pad_cnt  <= '0;
    end else begin
      if (out_valid && out_ready) beat_cnt <= beat_cnt + 16'd1;
      if (flush) pad_cnt <= pad_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_mac_operand_packer.sv
// tb/tb_mac_operand_packer.sv - randomized self-checking bench against a queue-based packing model
module tb_mac_operand_packer;

  localparam int BW_T  = 4;
  localparam int ROW_T = 8;
  localparam int DW    = BW_T * ROW_T;

  typedef struct {
    logic          mode;
    logic [DW-1:0] act;
    logic [DW-1:0] w;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_act = '0;
  logic [DW-1:0] in_w = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b0;
  logic [DW-1:0] out_b1;
  logic          out_last;
`ifdef PACKER_STATS_EN
  logic [15:0]   beat_cnt;
  logic [15:0]   pad_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int flushes  = 0;
  int pops     = 0;
  int cyc_used = 0;

  beat_t stim[$];
  exp_t  expq[$];

  always #5 clk = ~clk;

  mac_operand_packer #(.bw(BW_T), .row(ROW_T)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b0    (out_b0),
    .out_b1    (out_b1),
    .out_last  (out_last)
`ifdef PACKER_STATS_EN
    ,
    .beat_cnt  (beat_cnt),
    .pad_cnt   (pad_cnt)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: 4-bit mode passes beats through; 2-bit mode pairs beats lane-wise
  // as a = hi*4 + lo of the low two activation bits, odd tail padded with zeros.
  task automatic model_vec(input beat_t v[$]);
    exp_t e;
    int   n = v.size();
    foreach (v[k]) stim.push_back(v[k]);
    if (v[0].mode == 1'b0) begin
      foreach (v[k]) begin
        e.a = v[k].act; e.b0 = v[k].w; e.b1 = '0; e.last = v[k].last;
        expq.push_back(e);
      end
    end else begin
      for (int i = 0; i < n; i += 2) begin
        for (int l = 0; l < ROW_T; l++) begin
          int lo, hi;
          lo = int'(v[i].act[4*l +: 4]) % 4;
          hi = (i + 1 < n) ? int'(v[i+1].act[4*l +: 4]) % 4 : 0;
          e.a[4*l +: 4] = 4'(hi * 4 + lo);
        end
        e.b0 = v[i].w;
        if (i + 1 < n) begin
          e.b1 = v[i+1].w; e.last = v[i+1].last;
        end else begin
          e.b1 = '0; e.last = 1'b1; flushes++;
        end
        expq.push_back(e);
      end
    end
  endtask

  // Later beats carry the inverted mode to show it is ignored mid-vector.
  task automatic rand_vec(input logic m, input int n);
    beat_t v[$];
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.mode = (i == 0) ? m : ~m;
      b.act  = $urandom;
      b.w    = $urandom;
      b.last = (i == n - 1);
      v.push_back(b);
    end
    model_vec(v);
  endtask

  task automatic drive(input beat_t b);
    mode = b.mode; in_act = b.act; in_w = b.w; in_last = b.last;
  endtask

  task automatic check_out();
    if (out_valid) begin
      if (expq.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        check(out_ready ? "beat_a" : "hold_a", out_a, expq[0].a);
        check(out_ready ? "beat_b0" : "hold_b0", out_b0, expq[0].b0);
        check(out_ready ? "beat_b1" : "hold_b1", out_b1, expq[0].b1);
        check(out_ready ? "beat_last" : "hold_last", out_last, expq[0].last);
        if (out_ready) begin
          void'(expq.pop_front());
          pops++;
        end
      end
    end
    check("in_ready_rule", in_ready, !out_valid | out_ready);
  endtask

  // Entered and left just after a rising edge.
  task automatic run_stream(input int ready_pct, input int valid_pct, input int budget);
    int cyc = 0;
    bit acc;
    while ((stim.size() > 0 || expq.size() > 0) && cyc < budget) begin
      if (stim.size() > 0 && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        drive(stim[0]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      check_out();
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) void'(stim.pop_front());
      cyc++;
    end
    in_valid = 1'b0;
    cyc_used = cyc;
    if (cyc >= budget) check("stream_timeout", DW'(stim.size() + expq.size()), '0);
  endtask

  task automatic reset_checks(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_a"}, out_a, '0);
    check({tag, "_b0"}, out_b0, '0);
    check({tag, "_b1"}, out_b1, '0);
    check({tag, "_last"}, out_last, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    beat_t v[$];
    beat_t b;

    // Reset state
    @(posedge clk); #1;
    reset_checks("reset");

    // Mode 0 single beat, lane0 act=B w=9
    b.mode = 1'b0; b.act = 32'h0000_000B; b.w = 32'h0000_0009; b.last = 1'b1;
    v = {b}; model_vec(v);
    run_stream(100, 100, 50);
    check("t1_beats", DW'(pops), DW'(1));

    // Mode 1 pair: a=4'b0111, b0=3, b1=E
    b.mode = 1'b1; b.act = 32'h3; b.w = 32'h3; b.last = 1'b0; v = {b};
    b.act = 32'h1; b.w = 32'hE; b.last = 1'b1; v.push_back(b);
    model_vec(v);
    run_stream(100, 100, 50);

    // Mode 1 odd vector of 3 beats
    v.delete();
    for (int i = 1; i <= 3; i++) begin
      b.mode = 1'b1; b.act = DW'(i); b.w = 32'h1; b.last = (i == 3);
      v.push_back(b);
    end
    model_vec(v);
    run_stream(100, 100, 50);

    // Backpressure: hold one beat for 5 cycles while the next waits
    rand_vec(1'b0, 1);
    rand_vec(1'b0, 1);
    in_valid = 1'b1; drive(stim[0]); out_ready = 1'b0;
    @(posedge clk); #1;
    void'(stim.pop_front());
    drive(stim[0]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check_out();
      @(posedge clk); #1;
    end
    run_stream(100, 100, 50);

    // Throughput: 16 mode-0 beats in 16 cycles plus one drain cycle
    rand_vec(1'b0, 16);
    run_stream(100, 100, 100);
    check("throughput_cycles", DW'(cyc_used), DW'(17));

    // Mode toggled mid-vector
    rand_vec(1'b1, 4);
    rand_vec(1'b0, 3);
    run_stream(100, 100, 100);

    // Reset while holding a half-beat
    b.mode = 1'b1; b.act = $urandom; b.w = $urandom; b.last = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; drive(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    flushes = 0; pops = 0;
    reset_checks("mid_reset");
    rand_vec(1'b0, 1);
    rand_vec(1'b1, 2);
    run_stream(100, 100, 50);

    // Randomized vectors with random gaps and backpressure
    for (int k = 0; k < 40; k++) rand_vec(1'($urandom_range(1)), $urandom_range(1, 6));
    run_stream(70, 80, 3000);

`ifdef PACKER_STATS_EN
    @(negedge clk);
    check("beat_cnt", DW'(beat_cnt), DW'(pops));
    check("pad_cnt", DW'(pad_cnt), DW'(flushes));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
